axis_byte_upsizer: RTL and testbench
====================================

Name: axis_byte_upsizer

Overview:
- Downstream consumer of the 2:1 byte-stream mux output (m_data/m_valid/m_ready/m_last).
- Packs 8-bit stream beats into OUT_BYTES-wide words with a byte-keep mask, preserving packet boundaries.
- Feeds the wide datapath with full-rate, registered valid/ready handshaking.
- Counts completed output packets for status.

Parameters:
- OUT_BYTES, 4, bytes per output word; power of two, minimum 2.
- CNT_W, 16, width of the packet counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- s_data  input  8  input byte.
- s_valid  input  1  input beat valid.
- s_ready  output  1  block can accept a byte.
- s_last  input  1  byte is the last of its packet.
- m_data  output  8*OUT_BYTES  packed word; lane 0 (bits 7:0) holds the earliest byte.
- m_keep  output  OUT_BYTES  per-lane valid mask; always contiguous from lane 0.
- m_valid  output  1  output word valid.
- m_ready  input  1  downstream accepts the word.
- m_last  output  1  word ends a packet.
- pkt_cnt  output  CNT_W  number of packets completed on the output (m_valid&m_ready&m_last); wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, synchronous-to-clk deassert):
  - m_data=0, m_keep=0, m_valid=0, m_last=0, pkt_cnt=0.
  - Assembly register cleared; lane index = 0; hold flag cleared.
  - A partial packet in flight is discarded.
  - s_ready reads 1 in the first cycle after reset deasserts.
- Internal state:
  - Assembly register: data, keep, last.
  - Lane index: 0..OUT_BYTES-1.
  - asm_hold flag: a complete word is waiting for the output register.
  - Output register: m_data/m_keep/m_last/m_valid.
- Ready rule: s_ready = !asm_hold. It depends only on registered state, never on s_valid or m_ready.
- Accept: a byte transfers when s_valid && s_ready.
  - Byte is written to the lane given by the lane index; that keep bit is set.
- Word completes on an accepted byte when lane index = OUT_BYTES-1 or s_last=1.
  - If the output register is free or draining this cycle (!m_valid || m_ready):
    - The completed word (including this byte) loads directly into the output register; m_valid=1 next cycle.
    - Assembly register clears; lane index resets to 0.
  - Otherwise: asm_hold=1 and the word stays in the assembly register.
  - Non-completing byte: lane index increments; no output change.
- Hold drain: while asm_hold=1 and (!m_valid || m_ready):
  - Assembly word moves to the output register.
  - asm_hold clears; lane index resets to 0.
- Output handshake:
  - m_valid and all m_* stay stable until m_valid && m_ready.
  - After that transfer, m_valid drops next cycle unless a new word loads in the same edge.
- Latency: one cycle from the completing byte handshake to m_valid.
- Throughput: one byte per cycle when m_ready is held 1; s_ready never drops.
- Unused lanes (keep=0) read 0 in m_data.
- m_last=1 only on the word containing the byte accepted with s_last=1.
- Packet boundaries:
  - A new packet always starts in lane 0.
  - A packet of exactly k*OUT_BYTES bytes ends with a full keep mask and m_last=1; no empty trailing word is produced.
- pkt_cnt increments by 1 on each m_valid&&m_ready&&m_last; wraps from all-ones to 0.
- Maximum stall storage is two words (output plus assembly). Further input is blocked via s_ready=0.

Test Plan:
- 4-byte packet 11,22,33,44 (last on 44), m_ready=1 → one word: m_data=0x44332211, m_keep=1111, m_last=1, one cycle after the 44 handshake; pkt_cnt=1.
- 6-byte packet 01..06 → word 0x04030201 with keep=1111, last=0; then word 0x00000605 with keep=0011, last=1.
- 1-byte packet A5 → m_data=0x000000A5, keep=0001, last=1. Immediately followed by a 4-byte packet, which starts in lane 0.
- m_ready=0, stream 12 continuous bytes → words 1 and 2 are held; s_ready=0 from the cycle after byte 8 is accepted. Raise m_ready → all 3 words emerge in order with no loss or duplication.
- m_ready=1, 64 back-to-back bytes as 16 four-byte packets → s_ready stays 1 throughout; 16 words; pkt_cnt=16.
- Assert reset after 2 bytes of a packet, then send a 4-byte packet → all outputs are 0 during reset; the first output word contains only the new packet, with keep=1111 and pkt_cnt=1.

Source files
------------

// File: rtl/axis_byte_upsizer.sv
// axis_byte_upsizer: packs an 8-bit byte stream into OUT_BYTES-wide words
// with a contiguous keep mask, preserving packet boundaries.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   s_data/s_valid/s_ready/s_last           byte-wide input stream
//   m_data/m_keep/m_valid/m_ready/m_last    word-wide output stream
//                                           (lane 0 = earliest byte)
//   pkt_cnt           packets completed on the output, wraps
//
// Storage is an assembly register plus the output register; when both are
// occupied the input is blocked through the registered s_ready.
module axis_byte_upsizer #(
  parameter int unsigned OUT_BYTES = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   s_last,
  output logic [8*OUT_BYTES-1:0] m_data,
  output logic [OUT_BYTES-1:0]   m_keep,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic [CNT_W-1:0]       pkt_cnt
);

  localparam int unsigned DATA_W    = 8 * OUT_BYTES;
  localparam int unsigned LANE_W    = $clog2(OUT_BYTES);
  localparam int unsigned LAST_LANE = OUT_BYTES - 1;

  logic [DATA_W-1:0]    asm_data_q, asm_data_d;
  logic [OUT_BYTES-1:0] asm_keep_q, asm_keep_d;
  logic                 asm_last_q, asm_last_d;
  logic [LANE_W-1:0]    lane_q, lane_d;
  logic                 asm_hold_q, asm_hold_d;
  logic                 s_ready_q, s_ready_d;
  logic [DATA_W-1:0]    m_data_q, m_data_d;
  logic [OUT_BYTES-1:0] m_keep_q, m_keep_d;
  logic                 m_valid_q, m_valid_d;
  logic                 m_last_q, m_last_d;
  logic [CNT_W-1:0]     pkt_cnt_q, pkt_cnt_d;

  // Assembly word with the current byte merged in, plus handshake terms
  logic [DATA_W-1:0]    merge_data;
  logic [OUT_BYTES-1:0] merge_keep;
  logic                 out_free;
  logic                 accept;
  logic                 word_done;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      asm_data_q <= '0;
      asm_keep_q <= '0;
      asm_last_q <= 1'b0;
      lane_q     <= '0;
      asm_hold_q <= 1'b0;
      s_ready_q  <= 1'b1;
      m_data_q   <= '0;
      m_keep_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      pkt_cnt_q  <= '0;
    end else begin
      asm_data_q <= asm_data_d;
      asm_keep_q <= asm_keep_d;
      asm_last_q <= asm_last_d;
      lane_q     <= lane_d;
      asm_hold_q <= asm_hold_d;
      s_ready_q  <= s_ready_d;
      m_data_q   <= m_data_d;
      m_keep_q   <= m_keep_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  // Next-state: byte packing, hold drain, output handshake, packet count
  always_comb begin
    asm_data_d = asm_data_q;
    asm_keep_d = asm_keep_q;
    asm_last_d = asm_last_q;
    lane_d     = lane_q;
    asm_hold_d = asm_hold_q;
    m_data_d   = m_data_q;
    m_keep_d   = m_keep_q;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
    pkt_cnt_d  = pkt_cnt_q;

    out_free  = !m_valid_q || m_ready;
    accept    = s_valid && !asm_hold_q;
    word_done = accept && ((lane_q == LANE_W'(LAST_LANE)) || s_last);

    merge_data = asm_data_q;
    for (int i = 0; i < OUT_BYTES; i++) begin
      if (lane_q == LANE_W'(i)) merge_data[8*i +: 8] = s_data;
    end
    merge_keep = asm_keep_q | (OUT_BYTES'(1) << lane_q);

    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
      if (m_last_q) pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
    end

    if (asm_hold_q) begin
      // s_ready is low, so no byte can arrive while a held word drains
      if (out_free) begin
        m_data_d   = asm_data_q;
        m_keep_d   = asm_keep_q;
        m_last_d   = asm_last_q;
        m_valid_d  = 1'b1;
        asm_data_d = '0;
        asm_keep_d = '0;
        asm_last_d = 1'b0;
        lane_d     = '0;
        asm_hold_d = 1'b0;
      end
    end else if (accept) begin
      if (word_done) begin
        if (out_free) begin
          m_data_d   = merge_data;
          m_keep_d   = merge_keep;
          m_last_d   = s_last;
          m_valid_d  = 1'b1;
          asm_data_d = '0;
          asm_keep_d = '0;
          asm_last_d = 1'b0;
          lane_d     = '0;
        end else begin
          asm_data_d = merge_data;
          asm_keep_d = merge_keep;
          asm_last_d = s_last;
          asm_hold_d = 1'b1;
        end
      end else begin
        asm_data_d = merge_data;
        asm_keep_d = merge_keep;
        lane_d     = lane_q + LANE_W'(1);
      end
    end

    s_ready_d = !asm_hold_d;
  end

  assign s_ready = s_ready_q;
  assign m_data  = m_data_q;
  assign m_keep  = m_keep_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign pkt_cnt = pkt_cnt_q;

endmodule

// File: tb/tb_axis_byte_upsizer.sv
// Directed self-checking bench for axis_byte_upsizer (OUT_BYTES=4).
module tb_axis_byte_upsizer;

  logic        clk;
  logic        reset;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        s_last;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic [15:0] pkt_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] q_data[$];
  logic [3:0]  q_keep[$];
  logic        q_last[$];

  logic track_rdy = 1'b0;
  int   rdy_drops = 0;

  axis_byte_upsizer #(.OUT_BYTES(4), .CNT_W(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_last  (s_last),
    .m_data  (m_data),
    .m_keep  (m_keep),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last),
    .pkt_cnt (pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every output transfer; sampled mid-cycle
  always @(negedge clk) begin
    if (!reset && m_valid && m_ready) begin
      q_data.push_back(m_data);
      q_keep.push_back(m_keep);
      q_last.push_back(m_last);
    end
    if (track_rdy && !s_ready) rdy_drops++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one byte and hold it until accepted; returns #1 after the edge
  task automatic push(input logic [7:0] b, input logic last);
    bit done;
    done    = 1'b0;
    s_data  = b;
    s_last  = last;
    s_valid = 1'b1;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (s_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) check("push_timeout", 32'(done), 32'd1);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic expect_word(input string tag, input logic [31:0] d,
                             input logic [3:0] k, input logic l);
    int t;
    t = 0;
    while (q_data.size() == 0 && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (q_data.size() == 0) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_data"}, q_data.pop_front(), d);
      check({tag, "_keep"}, 32'(q_keep.pop_front()), 32'(k));
      check({tag, "_last"}, 32'(q_last.pop_front()), 32'(l));
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_m_data"},  m_data,       32'd0);
    check({tag, "_m_keep"},  32'(m_keep),  32'd0);
    check({tag, "_m_last"},  32'(m_last),  32'd0);
    check({tag, "_pkt_cnt"}, 32'(pkt_cnt), 32'd0);
  endtask

  initial begin
    reset   = 1'b1;
    s_data  = 8'h00;
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    cycles(3);
    check_reset_outputs("rst");
    reset = 1'b0;
    #1;
    check("rst_s_ready", 32'(s_ready), 32'd1);

    // Exact-fit packet: word appears one cycle after the last handshake
    push(8'h11, 1'b0);
    push(8'h22, 1'b0);
    push(8'h33, 1'b0);
    push(8'h44, 1'b1);
    check("p4_latency_valid", 32'(m_valid), 32'd1);
    check("p4_latency_data",  m_data, 32'h44332211);
    expect_word("p4", 32'h44332211, 4'b1111, 1'b1);
    cycles(2);
    check("p4_pkt_cnt", 32'(pkt_cnt), 32'd1);

    // Six bytes: full word then a two-lane tail
    for (int i = 1; i <= 6; i++) push(8'(i), (i == 6));
    expect_word("p6_w0", 32'h04030201, 4'b1111, 1'b0);
    expect_word("p6_w1", 32'h00000605, 4'b0011, 1'b1);

    // Single-byte packet followed immediately by a new packet in lane 0
    push(8'hA5, 1'b1);
    push(8'hB1, 1'b0);
    push(8'hB2, 1'b0);
    push(8'hB3, 1'b0);
    push(8'hB4, 1'b1);
    expect_word("p1", 32'h000000A5, 4'b0001, 1'b1);
    expect_word("p1_next", 32'hB4B3B2B1, 4'b1111, 1'b1);
    cycles(2);
    check("p1_pkt_cnt", 32'(pkt_cnt), 32'd4);

    // Backpressure: two words stored, then input blocks
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'hC0 + 8'(i), 1'b0);
    check("bp_s_ready_low", 32'(s_ready), 32'd0);
    check("bp_out_word", m_data, 32'hC4C3C2C1);
    cycles(3);
    check("bp_still_blocked", 32'(s_ready), 32'd0);
    check("bp_stable_data", m_data, 32'hC4C3C2C1);
    check("bp_no_transfer", 32'(q_data.size()), 32'd0);
    m_ready = 1'b1;
    for (int i = 9; i <= 12; i++) push(8'hC0 + 8'(i), (i == 12));
    expect_word("bp_w0", 32'hC4C3C2C1, 4'b1111, 1'b0);
    expect_word("bp_w1", 32'hC8C7C6C5, 4'b1111, 1'b0);
    expect_word("bp_w2", 32'hCCCBCAC9, 4'b1111, 1'b1);
    cycles(2);
    check("bp_no_extra", 32'(q_data.size()), 32'd0);
    check("bp_pkt_cnt", 32'(pkt_cnt), 32'd5);

    // Full-rate: 16 four-byte packets back to back
    track_rdy = 1'b1;
    for (int i = 0; i < 64; i++) push(8'(i), (i % 4 == 3));
    track_rdy = 1'b0;
    for (int p = 0; p < 16; p++) begin
      logic [31:0] w;
      w = {8'(4*p+3), 8'(4*p+2), 8'(4*p+1), 8'(4*p)};
      expect_word($sformatf("rate_w%0d", p), w, 4'b1111, 1'b1);
    end
    cycles(2);
    check("rate_s_ready_drops", 32'(rdy_drops), 32'd0);
    check("rate_pkt_cnt", 32'(pkt_cnt), 32'd21);

    // Reset mid-packet discards the partial bytes
    push(8'hD1, 1'b0);
    push(8'hD2, 1'b0);
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_rst_async");
    cycles(2);
    check_reset_outputs("mid_rst");
    reset = 1'b0;
    #1;
    check("mid_rst_s_ready", 32'(s_ready), 32'd1);
    q_data.delete();
    q_keep.delete();
    q_last.delete();
    push(8'hE1, 1'b0);
    push(8'hE2, 1'b0);
    push(8'hE3, 1'b0);
    push(8'hE4, 1'b1);
    expect_word("post_rst", 32'hE4E3E2E1, 4'b1111, 1'b1);
    cycles(2);
    check("post_rst_pkt_cnt", 32'(pkt_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
